// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg
// Shared definitions for the character-generator map controller:
// text geometry, map address width, command opcodes and the engine
// state encoding.
package vgachargen_pkg;

    localparam int MAP_W      = 80;
    localparam int MAP_H      = 30;
    localparam int MAP_DEPTH  = MAP_W * MAP_H;
    localparam int MAP_ADDR_W = 12;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_FILL   = 2'b01,
        OP_SCROLL = 2'b10,
        OP_RSVD   = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_CLEAR_ROW,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vgachargen_map_ctrl.sv
// vgachargen_map_ctrl
// Owns port A of the character map and colour map BRAMs. A host bus gets
// single-cycle read/write access to either map, while a bulk engine runs
// fill-screen and scroll-up commands. The bus normally wins each cycle;
// the engine is guaranteed progress after STARVE_LIMIT back-to-back bus
// grants, and the write half of a scroll step is never interrupted so
// the word read in the previous cycle is still on the BRAM output.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   bus_req_i/we_i/sel_i          host access request, write, map select
//   bus_addr_i/wdata_i            host cell address and write data
//   bus_gnt_o                     host access performed this cycle
//   bus_rvalid_o/rdata_o          host read data, one cycle after grant
//   cmd_valid_i/op_i              engine command handshake and opcode
//   cmd_char_i/color_i            fill character and colour
//   cmd_ready_o/busy_o/done_o     engine idle / active / completion pulse
//   ch_map_*                      character map BRAM port A
//   col_map_*                     colour map BRAM port A
module vgachargen_map_ctrl #(
    parameter int MAP_W        = vgachargen_pkg::MAP_W,
    parameter int MAP_H        = vgachargen_pkg::MAP_H,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                bus_req_i,
    input  logic                                bus_we_i,
    input  logic                                bus_sel_i,
    input  logic [vgachargen_pkg::MAP_ADDR_W-1:0] bus_addr_i,
    input  logic [7:0]                          bus_wdata_i,
    output logic                                bus_gnt_o,
    output logic                                bus_rvalid_o,
    output logic [7:0]                          bus_rdata_o,
    input  logic                                cmd_valid_i,
    input  logic [1:0]                          cmd_op_i,
    input  logic [7:0]                          cmd_char_i,
    input  logic [7:0]                          cmd_color_i,
    output logic                                cmd_ready_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [vgachargen_pkg::MAP_ADDR_W-1:0] ch_map_addr_o,
    output logic                                ch_map_wen_o,
    output logic [7:0]                          ch_map_wdata_o,
    input  logic [7:0]                          ch_map_rdata_i,
    output logic [vgachargen_pkg::MAP_ADDR_W-1:0] col_map_addr_o,
    output logic                                col_map_wen_o,
    output logic [7:0]                          col_map_wdata_o,
    input  logic [7:0]                          col_map_rdata_i
);

    import vgachargen_pkg::*;

    localparam int DEPTH    = MAP_W * MAP_H;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);

    localparam logic [MAP_ADDR_W-1:0] LAST_CELL   = MAP_ADDR_W'(DEPTH - 1);
    localparam logic [MAP_ADDR_W-1:0] LAST_SCROLL = MAP_ADDR_W'(DEPTH - MAP_W - 1);
    localparam logic [MAP_ADDR_W-1:0] ROW_STRIDE  = MAP_ADDR_W'(MAP_W);
    localparam logic [STARVE_W-1:0]   STARVE_CAP  = STARVE_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [MAP_ADDR_W-1:0] cell_q, cell_d;
    logic [7:0]            char_q, char_d;
    logic [7:0]            color_q, color_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  rvalid_q;
    logic                  rsel_q;

    logic engine_wants;
    logic engine_go;
    logic bus_gnt;

    // Arbitration. Reset gates the grant so nothing reaches the maps while
    // rst_ni is low. The starve counter only runs while the engine has
    // work pending, so it cannot block the bus in IDLE or DONE.
    always_comb begin
        engine_wants = (state_q == ST_FILL) || (state_q == ST_SCROLL_RD) ||
                       (state_q == ST_SCROLL_WR) || (state_q == ST_CLEAR_ROW);
        bus_gnt      = rst_ni && bus_req_i && (state_q != ST_SCROLL_WR) &&
                       !(engine_wants && (starve_q >= STARVE_CAP));
        engine_go    = engine_wants && !bus_gnt;
        starve_d     = (engine_wants && bus_gnt) ? starve_q + 1'b1 : '0;
    end

    // Engine next-state and status. The cell counter and state only move
    // on cycles the engine actually owns the maps.
    always_comb begin
        state_d     = state_q;
        cell_d      = cell_q;
        char_d      = char_q;
        color_d     = color_q;
        cmd_ready_o = (state_q == ST_IDLE);
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_e'(cmd_op_i))
                        OP_FILL: begin
                            char_d  = cmd_char_i;
                            color_d = cmd_color_i;
                            cell_d  = '0;
                            state_d = ST_FILL;
                        end
                        OP_SCROLL: begin
                            char_d  = cmd_char_i;
                            color_d = cmd_color_i;
                            cell_d  = '0;
                            state_d = ST_SCROLL_RD;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FILL, ST_CLEAR_ROW: begin
                if (engine_go) begin
                    if (cell_q == LAST_CELL) begin
                        state_d = ST_DONE;
                    end else begin
                        cell_d = cell_q + 1'b1;
                    end
                end
            end
            ST_SCROLL_RD: begin
                if (engine_go) begin
                    state_d = ST_SCROLL_WR;
                end
            end
            ST_SCROLL_WR: begin
                cell_d  = cell_q + 1'b1;
                state_d = (cell_q == LAST_SCROLL) ? ST_CLEAR_ROW : ST_SCROLL_RD;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Map port A drive. A scroll write forwards the BRAM output directly:
    // SCROLL_WR is only ever entered straight after the engine's own read,
    // so rdata holds the row-below word in exactly that cycle.
    always_comb begin
        ch_map_addr_o   = '0;
        ch_map_wen_o    = 1'b0;
        ch_map_wdata_o  = '0;
        col_map_addr_o  = '0;
        col_map_wen_o   = 1'b0;
        col_map_wdata_o = '0;

        if (bus_gnt) begin
            if (bus_sel_i) begin
                col_map_addr_o  = bus_addr_i;
                col_map_wen_o   = bus_we_i;
                col_map_wdata_o = bus_wdata_i;
            end else begin
                ch_map_addr_o   = bus_addr_i;
                ch_map_wen_o    = bus_we_i;
                ch_map_wdata_o  = bus_wdata_i;
            end
        end else if (engine_go) begin
            case (state_q)
                ST_FILL, ST_CLEAR_ROW: begin
                    ch_map_addr_o   = cell_q;
                    ch_map_wen_o    = 1'b1;
                    ch_map_wdata_o  = char_q;
                    col_map_addr_o  = cell_q;
                    col_map_wen_o   = 1'b1;
                    col_map_wdata_o = color_q;
                end
                ST_SCROLL_RD: begin
                    ch_map_addr_o  = cell_q + ROW_STRIDE;
                    col_map_addr_o = cell_q + ROW_STRIDE;
                end
                ST_SCROLL_WR: begin
                    ch_map_addr_o   = cell_q;
                    ch_map_wen_o    = 1'b1;
                    ch_map_wdata_o  = ch_map_rdata_i;
                    col_map_addr_o  = cell_q;
                    col_map_wen_o   = 1'b1;
                    col_map_wdata_o = col_map_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign bus_gnt_o    = bus_gnt;
    assign bus_rvalid_o = rvalid_q;
    assign bus_rdata_o  = !rvalid_q ? 8'h00 : (rsel_q ? col_map_rdata_i : ch_map_rdata_i);

    // State registers; a reset mid-command simply abandons the operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cell_q   <= '0;
            char_q   <= '0;
            color_q  <= '0;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            char_q   <= char_d;
            color_q  <= color_d;
            starve_q <= starve_d;
            rvalid_q <= bus_gnt && !bus_we_i;
            rsel_q   <= bus_sel_i;
        end
    end

endmodule

// File: tb/tb_vgachargen_map_ctrl.sv
// tb_vgachargen_map_ctrl
// Bench for the map controller: behavioural read-first BRAMs on both map
// ports, a vector table for single-cycle bus accesses, and directed
// sequences for fill, scroll, arbitration under load and mid-command reset.
module tb_vgachargen_map_ctrl;

    logic        clk;
    logic        rst_n;
    logic        bus_req, bus_we, bus_sel;
    logic [11:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_gnt_o, bus_rvalid_o;
    logic [7:0]  bus_rdata_o;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_char, cmd_color;
    logic        cmd_ready_o, busy_o, done_o;
    logic [11:0] ch_map_addr_o, col_map_addr_o;
    logic        ch_map_wen_o, col_map_wen_o;
    logic [7:0]  ch_map_wdata_o, col_map_wdata_o;
    logic [7:0]  ch_rdata, col_rdata;

    logic [7:0]  ch_mem  [0:4095];
    logic [7:0]  col_mem [0:4095];

    int tests;
    int fails;
    int done_pulses;
    logic mon_en;
    int wr_viol, rd_checks, rd_err;

    vgachargen_map_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus_req_i      (bus_req),
        .bus_we_i       (bus_we),
        .bus_sel_i      (bus_sel),
        .bus_addr_i     (bus_addr),
        .bus_wdata_i    (bus_wdata),
        .bus_gnt_o      (bus_gnt_o),
        .bus_rvalid_o   (bus_rvalid_o),
        .bus_rdata_o    (bus_rdata_o),
        .cmd_valid_i    (cmd_valid),
        .cmd_op_i       (cmd_op),
        .cmd_char_i     (cmd_char),
        .cmd_color_i    (cmd_color),
        .cmd_ready_o    (cmd_ready_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ch_map_addr_o  (ch_map_addr_o),
        .ch_map_wen_o   (ch_map_wen_o),
        .ch_map_wdata_o (ch_map_wdata_o),
        .ch_map_rdata_i (ch_rdata),
        .col_map_addr_o (col_map_addr_o),
        .col_map_wen_o  (col_map_wen_o),
        .col_map_wdata_o(col_map_wdata_o),
        .col_map_rdata_i(col_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM models with one cycle of read latency
    always @(posedge clk) begin
        if (ch_map_wen_o) ch_mem[ch_map_addr_o] <= ch_map_wdata_o;
        ch_rdata <= ch_mem[ch_map_addr_o];
        if (col_map_wen_o) col_mem[col_map_addr_o] <= col_map_wdata_o;
        col_rdata <= col_mem[col_map_addr_o];
    end

    always @(negedge clk) begin
        if (done_o) done_pulses++;
    end

    // Watches bus traffic during a scroll: no grant may follow an engine
    // read, and every granted read must return the model's memory word.
    always @(negedge clk) begin
        logic       prev_rd;
        logic       rd_pending;
        logic [7:0] rd_exp;
        if (mon_en) begin
            if (prev_rd && bus_gnt_o) wr_viol++;
            if (rd_pending) begin
                rd_checks++;
                if (!bus_rvalid_o || bus_rdata_o !== rd_exp) rd_err++;
            end
            prev_rd    = busy_o && !bus_gnt_o && !ch_map_wen_o && !done_o;
            rd_pending = bus_gnt_o && !bus_we;
            rd_exp     = bus_sel ? col_mem[bus_addr] : ch_mem[bus_addr];
        end else begin
            prev_rd    = 1'b0;
            rd_pending = 1'b0;
            rd_exp     = 8'h00;
        end
    end

    typedef struct {
        logic        req, we, sel;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic        gnt, ch_wen, col_wen;
        logic [11:0] ch_addr, col_addr;
        logic [7:0]  ch_wdata, col_wdata;
        logic        rvalid;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one command for a single cycle in IDLE
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] ch, input logic [7:0] col);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_char  = ch;
        cmd_color = col;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    task automatic waitDone(output int cycles, output int wens, output int gnts, input int limit);
        bit stop;
        cycles = 0;
        wens   = 0;
        gnts   = 0;
        stop   = 0;
        while (!stop) begin
            @(negedge clk);
            #1;
            if (done_o) begin
                stop = 1;
            end else begin
                if (ch_map_wen_o && col_map_wen_o) wens++;
                if (bus_gnt_o) gnts++;
                cycles++;
                if (cycles > limit) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL done timeout: no done_o after %0d cycles, required within %0d", cycles, limit);
                    stop = 1;
                end
            end
        end
    endtask

    task automatic runCommand(input string name, input logic [1:0] op, input logic [7:0] ch,
                              input logic [7:0] col, input int exp_cycles, input int exp_gnts,
                              input int release_after);
        int cycles, wens, gnts, d0;
        applyStimulus(op, ch, col);
        d0 = done_pulses;
        checkOutput({name, " busy"}, 32'(busy_o), 1);
        checkOutput({name, " cmd_ready low"}, 32'(cmd_ready_o), 0);
        fork
            waitDone(cycles, wens, gnts, 30000);
            begin
                if (release_after > 0) begin
                    repeat (release_after) @(posedge clk);
                    #2;
                    bus_req = 1'b0;
                end
            end
        join
        if (exp_cycles >= 0) checkOutput({name, " cycles"}, 32'(cycles), 32'(exp_cycles));
        if (exp_gnts >= 0) checkOutput({name, " bus grants"}, 32'(gnts), 32'(exp_gnts));
        checkOutput({name, " engine writes"}, 32'(wens), 2400);
        @(negedge clk);
        #1;
        checkOutput({name, " done one cycle"}, 32'(done_o), 0);
        checkOutput({name, " ready after"}, 32'(cmd_ready_o), 1);
        checkOutput({name, " done pulses"}, 32'(done_pulses - d0), 1);
    endtask

    task automatic checkFilled(input string name, input int lo, input int hi,
                               input logic [7:0] ch, input logic [7:0] col);
        int errs = 0;
        for (int a = lo; a <= hi; a++) begin
            if (ch_mem[a] !== ch || col_mem[a] !== col) errs++;
        end
        checkOutput({name, " bad cells"}, 32'(errs), 0);
    endtask

    // Row r gets char r and colour 0x80+r through ordinary bus writes
    task automatic preloadRows();
        for (int a = 0; a < 2400; a++) begin
            for (int m = 0; m < 2; m++) begin
                @(negedge clk);
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_sel   = m[0];
                bus_addr  = 12'(a);
                bus_wdata = (m == 0) ? 8'(a / 80) : 8'(8'h80 + a / 80);
            end
        end
        @(negedge clk);
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    initial begin
        int errs_ch, errs_col, r, d0;
        bit found;
        logic [7:0] ech, ecol;

        tests       = 0;
        fails       = 0;
        done_pulses = 0;
        mon_en      = 1'b0;
        wr_viol     = 0;
        rd_checks   = 0;
        rd_err      = 0;
        rst_n       = 1'b0;
        bus_req     = 1'b1;
        bus_we      = 1'b1;
        bus_sel     = 1'b0;
        bus_addr    = 12'd5;
        bus_wdata   = 8'h5A;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_char    = 8'h00;
        cmd_color   = 8'h00;

        // Reset holds everything quiet even with a bus request pending
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset gnt", 32'(bus_gnt_o), 0);
        checkOutput("reset ch_wen", 32'(ch_map_wen_o), 0);
        checkOutput("reset ch_addr", 32'(ch_map_addr_o), 0);
        checkOutput("reset ch_wdata", 32'(ch_map_wdata_o), 0);
        checkOutput("reset busy", 32'(busy_o), 0);
        checkOutput("reset done", 32'(done_o), 0);
        checkOutput("reset rvalid", 32'(bus_rvalid_o), 0);
        checkOutput("reset rdata", 32'(bus_rdata_o), 0);
        bus_req = 1'b0;
        bus_we  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 12'h00A, 8'h55, 1'b1, 1'b1, 1'b0, 12'h00A, 12'h000, 8'h55, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 12'h00A, 8'hAA, 1'b1, 1'b0, 1'b1, 12'h000, 12'h00A, 8'h00, 8'hAA, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 12'h00A, 8'h00, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 8'h00, 8'h00, 1'b1, 8'h55};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 12'h00A, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000, 12'h00A, 8'h00, 8'h00, 1'b1, 8'hAA};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 12'hBB8, 8'h77, 1'b1, 1'b1, 1'b0, 12'hBB8, 12'h000, 8'h77, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 12'hBB8, 8'h00, 1'b1, 1'b0, 1'b0, 12'hBB8, 12'h000, 8'h00, 8'h00, 1'b1, 8'h77};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 12'hFFF, 8'h3C, 1'b1, 1'b0, 1'b1, 12'h000, 12'hFFF, 8'h00, 8'h3C, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 12'hFFF, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000, 12'hFFF, 8'h00, 8'h00, 1'b1, 8'h3C};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 12'h00A, 8'h00, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 8'h00, 8'h00, 1'b1, 8'h55};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 8'h00, 8'h00, 1'b0, 8'h00};

        foreach (vecs[i]) begin
            @(negedge clk);
            bus_req   = vecs[i].req;
            bus_we    = vecs[i].we;
            bus_sel   = vecs[i].sel;
            bus_addr  = vecs[i].addr;
            bus_wdata = vecs[i].wdata;
            #1;
            checkOutput($sformatf("vec%0d gnt", i), 32'(bus_gnt_o), 32'(vecs[i].gnt));
            checkOutput($sformatf("vec%0d ch_wen", i), 32'(ch_map_wen_o), 32'(vecs[i].ch_wen));
            checkOutput($sformatf("vec%0d col_wen", i), 32'(col_map_wen_o), 32'(vecs[i].col_wen));
            checkOutput($sformatf("vec%0d ch_addr", i), 32'(ch_map_addr_o), 32'(vecs[i].ch_addr));
            checkOutput($sformatf("vec%0d col_addr", i), 32'(col_map_addr_o), 32'(vecs[i].col_addr));
            checkOutput($sformatf("vec%0d ch_wdata", i), 32'(ch_map_wdata_o), 32'(vecs[i].ch_wdata));
            checkOutput($sformatf("vec%0d col_wdata", i), 32'(col_map_wdata_o), 32'(vecs[i].col_wdata));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d rvalid", i), 32'(bus_rvalid_o), 32'(vecs[i].rvalid));
            checkOutput($sformatf("vec%0d rdata", i), 32'(bus_rdata_o), 32'(vecs[i].rdata));
        end
        bus_req = 1'b0;

        // Reserved and nop opcodes are swallowed
        for (int k = 0; k < 2; k++) begin
            int wen_seen;
            d0 = done_pulses;
            applyStimulus((k == 0) ? 2'b11 : 2'b00, 8'h99, 8'h99);
            checkOutput($sformatf("op%0d ready", k), 32'(cmd_ready_o), 1);
            checkOutput($sformatf("op%0d busy", k), 32'(busy_o), 0);
            wen_seen = 0;
            repeat (4) begin
                @(negedge clk);
                #1;
                if (ch_map_wen_o || col_map_wen_o || busy_o) wen_seen++;
            end
            checkOutput($sformatf("op%0d no activity", k), 32'(wen_seen), 0);
            checkOutput($sformatf("op%0d no done", k), 32'(done_pulses - d0), 0);
        end

        runCommand("fill41", 2'b01, 8'h41, 8'hF0, 2400, 0, 0);
        checkFilled("fill41", 0, 2399, 8'h41, 8'hF0);

        preloadRows();
        runCommand("scroll1", 2'b10, 8'h20, 8'h07, 4720, 0, 0);
        errs_ch  = 0;
        errs_col = 0;
        for (int a = 0; a < 2400; a++) begin
            r    = a / 80;
            ech  = (r < 29) ? 8'(r + 1) : 8'h20;
            ecol = (r < 29) ? 8'(8'h81 + r) : 8'h07;
            if (ch_mem[a] !== ech) errs_ch++;
            if (col_mem[a] !== ecol) errs_col++;
        end
        checkOutput("scroll1 char cells", 32'(errs_ch), 0);
        checkOutput("scroll1 colour cells", 32'(errs_col), 0);

        // Second scroll with a colour-map read of cell 5 hammering the bus
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_sel  = 1'b1;
        bus_addr = 12'd5;
        mon_en   = 1'b1;
        runCommand("scroll2", 2'b10, 8'h2E, 8'h0C, -1, -1, 200);
        mon_en = 1'b0;
        checkOutput("scroll2 grant after engine read", 32'(wr_viol), 0);
        checkOutput("scroll2 bus reads seen", 32'(rd_checks > 20), 1);
        checkOutput("scroll2 bus read data", 32'(rd_err), 0);
        errs_ch  = 0;
        errs_col = 0;
        for (int a = 0; a < 2400; a++) begin
            r    = a / 80;
            ech  = (r < 28) ? 8'(r + 2) : ((r == 28) ? 8'h20 : 8'h2E);
            ecol = (r < 28) ? 8'(8'h82 + r) : ((r == 28) ? 8'h07 : 8'h0C);
            if (ch_mem[a] !== ech) errs_ch++;
            if (col_mem[a] !== ecol) errs_col++;
        end
        checkOutput("scroll2 char cells", 32'(errs_ch), 0);
        checkOutput("scroll2 colour cells", 32'(errs_col), 0);

        // Bus held for the whole fill: four grants then one engine cycle
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_sel  = 1'b0;
        bus_addr = 12'd7;
        runCommand("fillbus", 2'b01, 8'h5A, 8'hA5, 12000, 9600, 0);
        bus_req = 1'b0;
        checkFilled("fillbus", 0, 2399, 8'h5A, 8'hA5);

        // Reset while the engine is about to write cell 1000
        d0 = done_pulses;
        applyStimulus(2'b01, 8'h11, 8'h22);
        found = 0;
        for (int n = 0; n < 5000 && !found; n++) begin
            @(negedge clk);
            #1;
            if (ch_map_wen_o && ch_map_addr_o == 12'd1000) found = 1;
        end
        checkOutput("abort reached cell 1000", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy_o), 0);
        checkOutput("abort ready", 32'(cmd_ready_o), 1);
        checkOutput("abort ch_wen", 32'(ch_map_wen_o), 0);
        checkOutput("abort col_wen", 32'(col_map_wen_o), 0);
        checkOutput("abort ch_addr", 32'(ch_map_addr_o), 0);
        checkOutput("abort col_wdata", 32'(col_map_wdata_o), 0);
        checkOutput("abort done", 32'(done_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("abort no done pulse", 32'(done_pulses - d0), 0);
        checkFilled("abort head", 0, 999, 8'h11, 8'h22);
        checkFilled("abort tail", 1000, 2399, 8'h5A, 8'hA5);

        runCommand("refill", 2'b01, 8'h33, 8'h0F, 2400, 0, 0);
        checkFilled("refill", 0, 2399, 8'h33, 8'h0F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vgachargen_map_ctrl.md
VGACHARGEN_MAP_CTRL -- requirements
Module: vgachargen_map_ctrl

Interface
REQ-001 SHALL have one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-002 SHALL expose parameters: MAP_W, default 80, text columns; MAP_H, default 30, text rows; STARVE_LIMIT, default 4, max consecutive bus grants while the engine is busy.
REQ-003 clk_i  in  1  system clock.
REQ-004 rst_ni  in  1  async active-low reset.
REQ-005 bus_req_i  in  1  bus access request; bus_we_i  in  1  write when high; bus_sel_i  in  1  0 = char map, 1 = colour map.
REQ-006 bus_addr_i  in  12  cell address; bus_wdata_i  in  8  write data.
REQ-007 bus_gnt_o  out  1  access performed this cycle; bus_rvalid_o  out  1  read data valid; bus_rdata_o  out  8  read data.
REQ-008 cmd_valid_i  in  1  command request; cmd_op_i  in  2  00 nop, 01 fill, 10 scroll-up, 11 reserved.
REQ-009 cmd_char_i  in  8  fill character; cmd_color_i  in  8  fill colour {fg,bg}.
REQ-010 cmd_ready_o  out  1  engine idle; busy_o  out  1  engine active; done_o  out  1  one-cycle completion pulse.
REQ-011 ch_map_addr_o  out  12; ch_map_wen_o  out  1; ch_map_wdata_o  out  8; ch_map_rdata_i  in  8  char map port A, 1-cycle read latency.
REQ-012 col_map_addr_o  out  12; col_map_wen_o  out  1; col_map_wdata_o  out  8; col_map_rdata_i  in  8  colour map port A, same timing.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, SCROLL_RD, SCROLL_WR, CLEAR_ROW, DONE.
REQ-014 In IDLE, cmd_ready_o=1; a command is accepted when cmd_valid_i&cmd_ready_o, and cmd_char_i/cmd_color_i are latched at acceptance.
REQ-015 Accepted op 00 or 11 SHALL be discarded: no state change, no done_o.
REQ-016 FILL: one cell per engine cycle, addresses 0..MAP_W*MAP_H-1 (0..2399); both maps written with the latched char/colour.
REQ-017 Scroll-up: for a = 0..2319, SCROLL_RD drives address a+80 on both maps; the following SCROLL_WR writes the captured rdata to address a. CLEAR_ROW then writes addresses 2320..2399 with the latched char/colour.
REQ-018 After the last engine write, DONE SHALL assert done_o for exactly one cycle, then return to IDLE; busy_o=1 in every state except IDLE.
REQ-019 Without bus traffic, fill SHALL take 2400 engine cycles and scroll 4720 (2*2320+80).
REQ-020 Arbitration: bus_req_i wins a cycle over the engine, except (a) in SCROLL_WR and (b) after STARVE_LIMIT consecutive grants while busy_o=1, when the engine gets the next cycle.
REQ-021 A granted bus cycle SHALL drive bus_addr_i to the map selected by bus_sel_i; the wen of that map = bus_we_i. The other map is idle. bus_gnt_o=1 combinationally in that cycle.
REQ-022 A granted bus read SHALL give bus_rvalid_o=1 one cycle later, with bus_rdata_o from the selected map's rdata.
REQ-023 A stalled engine SHALL hold its address counter and state. In SCROLL_RD, the read data is captured only in the cycle directly after an engine read.
REQ-024 Bus writes to cells the engine has not yet processed SHALL be overwritten by the engine; that is permitted behaviour.
REQ-025 Addresses >= 2400 from the bus SHALL be passed through unchanged; the BRAM wraps them.
REQ-026 When no one is granted, all wen outputs SHALL be 0.

Reset
REQ-027 While rst_ni=0: state=IDLE, counters 0, all *_wen_o, bus_gnt_o, bus_rvalid_o, done_o and busy_o = 0, addresses/wdata/bus_rdata_o = 0.
REQ-028 Reset during FILL/scroll SHALL abort immediately with no done_o; map contents are left partially updated.

Structure
REQ-029 Package vgachargen_pkg SHALL hold MAP_W, MAP_H, MAP_DEPTH=2400, MAP_ADDR_W=12, the cmd_op enum and the FSM state enum.
REQ-030 Single module, no sub-modules; the map BRAMs stay outside it, on their port A.

Verification
REQ-031 Fill with char 0x41, colour 0xF0, no bus traffic -> 2400 cycles with wen=1; every cell reads back 0x41/0xF0; done_o pulses once.
REQ-032 Preload row r with char r, then scroll-up with char 0x20 -> row r holds r+1 for r<29, row 29 holds 0x20; done after 4720 cycles.
REQ-033 bus_req_i held high during fill -> 4 grants, then 1 engine cycle, repeating; fill completes in 12000 cycles.
REQ-034 During scroll, bus read of colour addr 5 -> never granted in SCROLL_WR; rvalid 1 cycle after grant with correct data; scroll result unchanged.
REQ-035 rst_ni low at fill cell 1000 -> outputs zero, IDLE, no done_o; a new fill then completes normally.
REQ-036 cmd_op 11 accepted -> cmd_ready_o stays 1, no writes, no done_o.
